fft_frame_reader: RTL and testbench
===================================

Name: fft_frame_reader

Overview:
- Read-side sequencer for the FFT sample buffer: on `start`, reads `thresh+1` consecutive words from a synchronous single-port RAM.
- Streams the words out on a valid/ready interface with `out_last` on the final beat.
- Pairs with the write-side sample counter, which fills the buffer.
- Sits between the sample RAM and the butterfly datapath / output stage.

Parameters:
- DATA_WIDTH, 32, sample word width (packed re/im).
- ADDR_WIDTH, 8, RAM address width; the maximum frame is 2^ADDR_WIDTH samples (256).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame request pulse; sampled only in IDLE.
- thresh  input  ADDR_WIDTH  index of the last sample (frame length − 1); latched on an accepted start.
- rd_en  output  1  RAM read enable.
- rd_addr  output  ADDR_WIDTH  RAM read address.
- rd_data  input  DATA_WIDTH  RAM read data, valid exactly one cycle after rd_en.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH  stream data.
- out_last  output  1  marks the final beat of the frame.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - rd_en, rd_addr, out_valid, out_data, out_last, busy and done all 0.
  - Skid buffer emptied; in-flight read data discarded.
  - Reset mid-frame aborts the frame silently; no done pulse.
- FSM states:
  - IDLE: start=1 latches thresh, clears the index counter, goes to RUN.
  - RUN: issues reads under the credit rule below. When the read with index==thresh issues, goes to DRAIN.
  - DRAIN: no reads. On the handshake of the out_last beat, goes to IDLE and sets done=1 for the next cycle.
- start outside IDLE is ignored. start in the cycle done is high is accepted, because state is already IDLE.
- Credit rule:
  - Skid buffer depth is 2.
  - rd_en=1 in a cycle only if (occupancy + in-flight reads − pop this cycle) < 2.
  - A pop is out_valid && out_ready.
  - Consequence: no overflow, and sustained 1 beat/cycle while out_ready stays high.
- Addressing:
  - A read index counter of width ADDR_WIDTH increments on each issued read.
  - rd_addr = index, or its bit reversal (see Optional Feature).
- Latency:
  - start accepted at edge E0; first rd_en in the cycle after E0.
  - rd_data is written into the buffer at E2.
  - out_valid first high after E2, i.e. 3 cycles start-to-data.
- Stream rules:
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid never drops without a handshake.
  - Beat k carries RAM word k, in issue order.
- out_last: high on exactly one beat, the (thresh+1)-th.
- Boundaries:
  - thresh=0 gives a single beat with out_last=1.
  - thresh=2^ADDR_WIDTH−1 gives a full frame; the index counter wraps to 0 and is unused afterwards.
  - out_ready held low stalls after at most 2 reads are outstanding or buffered.
- Arithmetic: the frame-length compare is on index equality with latched thresh. Unsigned throughout, no overflow paths.

Optional Feature:
- Macro: FFT_FRAME_READER_BITREV_EN.
- Defined: rd_addr = bit-reverse(index) over ADDR_WIDTH bits, so samples stream out in bit-reversed order for the radix-2 DIT input.
  - out_last is still the (thresh+1)-th beat.
  - Only meaningful when thresh = 2^ADDR_WIDTH−1.
- Undefined: rd_addr = index (natural order); no reversal logic is compiled.

Decomposition:
- Shared package fft_pkg holds:
  - The state encoding (IDLE, RUN, DRAIN).
  - FFT_N=256 and its log2 (8), shared with the write-side counter.
  - A bitrev function parameterised on width.
- One natural sub-module: fft_skid_buf.
  - A 2-entry valid/ready buffer with push, pop and occupancy output.
  - It holds the data and last bit.

Test Plan:
- RAM preloaded with word[i]=i; start with thresh=7, out_ready=1 -> 8 beats, data 0..7 on consecutive cycles, out_last on data 7, done 1 cycle after, busy low with done.
- thresh=0 -> exactly one beat, data 0 with out_last=1; done follows; rd_en asserted exactly once.
- thresh=15, out_ready toggled 1010... then held low for 10 cycles mid-frame -> data 0..15 in order with none lost or duplicated; stalled beat held stable; at most 2 reads outstanding or buffered during the stall.
- start pulsed again during RUN and at the done cycle -> the mid-frame start is ignored; the done-cycle start launches a second frame with a 3-cycle first-data latency.
- rst asserted while 5 of 16 beats are accepted -> all outputs 0 immediately, no done pulse; a later start with thresh=3 gives beats 0..3 cleanly.
- With FFT_FRAME_READER_BITREV_EN and thresh=255 -> rd_addr sequence 0,128,64,192,...; beat k carries bitrev8(k); out_last on beat 255.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants, read-sequencer state encoding and address bit reversal.
// Used by the read-side frame reader and the write-side sample counter.
package fft_pkg;

    localparam int unsigned FFT_N     = 256;
    localparam int unsigned FFT_LOG2N = $clog2(FFT_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Reverse the low `width` bits of x; bits above width are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) r[5'(i)] = x[5'(width - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry valid/ready buffer between RAM read data and the output stream.
// Entry 0 is always the head, so the stream payload comes straight from a register.
module fft_skid_buf #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_data;
                    else             tail <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
                2'b11: begin
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= push_data;
                    end else begin
                        head <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (occ != 2'd0);

endmodule

// File: rtl/fft_frame_reader.sv
// Read-side sequencer: streams thresh+1 sample-RAM words out on a valid/ready port.
// Define FFT_FRAME_READER_BITREV_EN to issue addresses in bit-reversed order.
module fft_frame_reader
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = FFT_LOG2N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] thresh,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BUF_W = DATA_WIDTH + 1;

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH-1:0] thresh_q;
    logic                  inflight;
    logic                  inflight_last;
    logic                  pop;
    logic                  credit_ok;
    logic                  last_issue;
    logic [1:0]            occ;
    logic [2:0]            fill;
    logic [BUF_W-1:0]      head;

    assign pop        = out_valid && out_ready;
    assign last_issue = (index == thresh_q);

    // A read may issue only if buffered + in-flight words, less this cycle's pop, leave a free slot.
    assign fill      = 3'(occ) + 3'(inflight);
    assign credit_ok = fill < (3'd2 + 3'(pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)               state_nxt = RUN;
            RUN:     if (rd_en && last_issue) state_nxt = DRAIN;
            DRAIN:   if (pop && out_last)     state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        case (state)
            RUN: begin
                rd_en = credit_ok;
                busy  = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index         <= '0;
            thresh_q      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= rd_en;
            inflight_last <= rd_en && last_issue;
            done          <= (state == DRAIN) && pop && out_last;
            if (state == IDLE && start) begin
                thresh_q <= thresh;
                index    <= '0;
            end else if (rd_en) begin
                index <= index + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef FFT_FRAME_READER_BITREV_EN
    assign rd_addr = ADDR_WIDTH'(bitrev(32'(index), ADDR_WIDTH));
`else
    assign rd_addr = index;
`endif

    fft_skid_buf #(
        .WIDTH (BUF_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, rd_data}),
        .pop       (pop),
        .valid     (out_valid),
        .head      (head),
        .occ       (occ)
    );

    assign out_data = head[DATA_WIDTH-1:0];
    assign out_last = head[DATA_WIDTH];

endmodule

// File: tb/tb_fft_frame_reader.sv
// Directed self-checking bench for fft_frame_reader against a synchronous RAM model holding word[i]=i.
module tb_fft_frame_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] thresh;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    int reads;

    logic [DW-1:0] ram [256];

    fft_frame_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .thresh    (thresh),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    // Word expected on beat k (and address of read k), given word[i]=i in the RAM.
    function automatic logic [31:0] exp_word(input int k);
        logic [7:0] a;
        logic [7:0] r;
        a = 8'(k);
`ifdef FFT_FRAME_READER_BITREV_EN
        for (int i = 0; i < 8; i++) r[i] = a[7-i];
`else
        r = a;
`endif
        return 32'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int th);
        thresh = 8'(th);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        thresh = 8'($urandom);
    endtask

    // mode 0: ready always high; 1: ready 1010.. then low 10 cycles; 2: ready high plus stray starts.
    task automatic collect(input int nb, input int th, input int mode, output int n_reads);
        int beat, cyc, first_valid, last_cyc;
        logic stalled, hold_l;
        logic [DW-1:0] hold_d;
        beat = 0; cyc = 0; n_reads = 0; first_valid = -1; last_cyc = -1;
        stalled = 1'b0; hold_l = 1'b0; hold_d = '0;
        while (beat < nb && cyc < 2000) begin
            if (mode == 1) out_ready = (cyc >= 8 && cyc < 18) ? 1'b0 : (cyc % 2 == 0);
            else           out_ready = 1'b1;
            start = (mode == 2 && (cyc == 4 || cyc == 9));
            if (start) thresh = 8'(cyc);
            #1;
            if (cyc == 0) chk("first_rd_en", 32'(rd_en), 32'd1);
            chk("no_early_done", 32'(done), 32'd0);
            chk("busy_high", 32'(busy), 32'd1);
            if (rd_en) begin
                chk("rd_addr", 32'(rd_addr), exp_word(n_reads));
                n_reads++;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, hold_d);
                chk("stall_last", 32'(out_last), 32'(hold_l));
            end
            if (out_valid && out_ready) begin
                chk("beat_data", out_data, exp_word(beat));
                chk("beat_last", 32'(out_last), 32'(beat == th));
                beat++;
                last_cyc = cyc;
                stalled  = 1'b0;
            end else begin
                stalled = out_valid;
                hold_d  = out_data;
                hold_l  = out_last;
            end
            chk("credit_bound", 32'(n_reads - beat <= 2), 32'd1);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("beats_seen", 32'(beat), 32'(nb));
        chk("first_data_latency", 32'(first_valid), 32'd2);
        if (mode == 0) chk("last_beat_cycle", 32'(last_cyc), 32'(nb + 1));
    endtask

    task automatic frame_end(input bit keep_cycle);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_low_with_done", 32'(busy), 32'd0);
        chk("valid_low_after", 32'(out_valid), 32'd0);
        chk("rd_en_low_after", 32'(rd_en), 32'd0);
        if (!keep_cycle) begin
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; thresh = '0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = DW'(i);
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 8-beat frame at full rate
        do_start(7);
        collect(8, 7, 0, reads);
        chk("t1_reads", 32'(reads), 32'd8);
        frame_end(1'b0);

        // single-beat frame
        do_start(0);
        collect(1, 0, 0, reads);
        chk("t2_reads", 32'(reads), 32'd1);
        frame_end(1'b0);

        // toggling then stalled ready
        do_start(15);
        collect(16, 15, 1, reads);
        chk("t3_reads", 32'(reads), 32'd16);
        frame_end(1'b0);

        // stray starts mid-frame, then a start in the done cycle
        do_start(15);
        collect(16, 15, 2, reads);
        chk("t4_reads", 32'(reads), 32'd16);
        frame_end(1'b1);
        do_start(3);
        collect(4, 3, 0, reads);
        chk("t4b_reads", 32'(reads), 32'd4);
        frame_end(1'b0);

        // reset after 5 of 16 beats
        do_start(15);
        collect(5, 15, 0, reads);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end
        do_start(3);
        collect(4, 3, 0, reads);
        chk("t5_reads", 32'(reads), 32'd4);
        frame_end(1'b0);

        // full 256-sample frame
        do_start(255);
        collect(256, 255, 0, reads);
        chk("t6_reads", 32'(reads), 32'd256);
        frame_end(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
